// File: rtl/dm_access_ctrl.sv
// Memory-stage access controller: turns load/store requests into DM word accesses, with RMW for sh/sb.
// Optional macro DM_RANGE_CHECK_EN rejects addresses at or above ADDR_LIMIT like misaligned ones.
module dm_access_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        addr_err
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state;
  logic [31:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_byte;
  logic [31:0] cap_pc;

  logic        misaligned, out_of_range, bad, is_load;
  logic [31:0] load_ext, merged;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

`ifdef DM_RANGE_CHECK_EN
  assign out_of_range = (addr >= ADDR_LIMIT);
`else
  logic unused_range;
  assign unused_range = (addr >= ADDR_LIMIT);
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign bad     = misaligned | out_of_range;
  assign is_load = (op <= OP_LBU);

  // Lane extraction and extension for loads
  always_comb begin
    half_sel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    byte_sel = dm_rdata[{addr[1:0], 3'b000} +: 8];
    case (op)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = dm_rdata;
    endcase
  end

  // Replace only the captured lane of the current DM word
  always_comb begin
    merged = dm_rdata;
    if (cap_byte)
      merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
    else if (cap_addr[1])
      merged[31:16] = cap_wdata;
    else
      merged[15:0] = cap_wdata;
  end

  always_comb begin
    busy = (state == MERGE);
    if (state == MERGE) begin
      dm_addr  = {cap_addr[31:2], 2'b00};
      dm_pc    = cap_pc;
      dm_wdata = merged;
      dm_we    = ~reset;
    end else begin
      dm_addr  = {addr[31:2], 2'b00};
      dm_pc    = pc;
      dm_wdata = wdata;
      dm_we    = req & (op == OP_SW) & ~bad & ~reset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= 32'h0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      cap_addr  <= 32'h0;
      cap_wdata <= 16'h0;
      cap_byte  <= 1'b0;
      cap_pc    <= 32'h0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              addr_err <= 1'b1;
            end else if (is_load) begin
              rdata <= load_ext;
              done  <= 1'b1;
            end else if (op == OP_SW) begin
              done <= 1'b1;
            end else begin
              cap_addr  <= addr;
              cap_wdata <= wdata[15:0];
              cap_byte  <= (op != OP_SH);
              cap_pc    <= pc;
              state     <= MERGE;
            end
          end
        end
        MERGE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
